// File: rtl/decode_exec_unit.sv
// Decode/execute stage: takes a two-word instruction, fetches operands from
// the GPR file and/or RAM, applies move/inc/dec and emits one write-back record.
module decode_exec_unit #(
    parameter int unsigned DATA_W  = 14,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned GPR_AW  = 4,
    parameter int unsigned OPC_W   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            instr_valid,
    output logic                            instr_ready,
    input  logic [2*DATA_W-1:0]             instr,
    output logic                            gpr_rd_en,
    output logic [GPR_AW-1:0]               gpr_rd_addr,
    input  logic [DATA_W-1:0]               gpr_rd_data,
    output logic                            ram_rd_req,
    output logic [ADDR_W-1:0]               ram_rd_addr,
    input  logic                            ram_rd_gnt,
    input  logic [DATA_W-1:0]               ram_rd_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W+ADDR_W+OPC_W-1:0]  out_data,
    output logic                            out_dst_ram,
    output logic                            err_illegal,
    output logic                            err_timeout
);

    localparam int unsigned IW      = 2 * DATA_W;
    localparam int unsigned REC_W   = DATA_W + ADDR_W + OPC_W;
    localparam int unsigned USED_W  = OPC_W + 2 * GPR_AW + ADDR_W;
    localparam int unsigned RD_MSB  = IW - 1 - OPC_W;
    localparam int unsigned AD_MSB  = RD_MSB - GPR_AW;
    localparam int unsigned RS_MSB  = AD_MSB - ADDR_W;
    localparam int unsigned SPARE_W = IW - USED_W;
    localparam int unsigned CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GPR_RD  = 3'd1;
    localparam logic [2:0] S_GPR_CAP = 3'd2;
    localparam logic [2:0] S_RAM_RD  = 3'd3;
    localparam logic [2:0] S_EXEC    = 3'd4;
    localparam logic [2:0] S_OUT     = 3'd5;

    localparam logic [OPC_W-1:0] OP_MOV_SR  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_MOV_SA  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_MOV_BIO = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_INC_SR  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_INC_BIO = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_DEC_SR  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_DEC_BIO = OPC_W'(6);

    // Refuse field layouts that do not fit the instruction or the pointer path.
    if ((USED_W > IW) || (GPR_AW > ADDR_W) || (ADDR_W > DATA_W)) begin : g_param_check
        $error("decode_exec_unit: illegal parameter combination");
    end

    // Trailing instruction bits carry no fields.
    if (SPARE_W > 0) begin : g_spare
        logic unused_spare;
        assign unused_spare = ^instr[SPARE_W-1:0];
    end

    logic [OPC_W-1:0]  in_opc;
    logic [GPR_AW-1:0] in_rd;
    logic [ADDR_W-1:0] in_addr;
    logic [GPR_AW-1:0] in_rs;

    assign in_opc  = instr[IW-1 -: OPC_W];
    assign in_rd   = instr[RD_MSB -: GPR_AW];
    assign in_addr = instr[AD_MSB -: ADDR_W];
    assign in_rs   = instr[RS_MSB -: GPR_AW];

    logic [2:0]        state_q, state_d;
    logic [OPC_W-1:0]  opc_q, opc_d;
    logic [GPR_AW-1:0] rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              instr_ready_d, gpr_rd_en_d, ram_rd_req_d, out_valid_d;
    logic              out_dst_ram_d, err_illegal_d, err_timeout_d;
    logic [GPR_AW-1:0] gpr_rd_addr_d;
    logic [ADDR_W-1:0] ram_rd_addr_d;
    logic [REC_W-1:0]  out_data_d;

    // State, operand and registered-output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            opc_q       <= '0;
            rd_q        <= '0;
            addr_q      <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            instr_ready <= 1'b0;
            gpr_rd_en   <= 1'b0;
            gpr_rd_addr <= '0;
            ram_rd_req  <= 1'b0;
            ram_rd_addr <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_dst_ram <= 1'b0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            opc_q       <= opc_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            instr_ready <= instr_ready_d;
            gpr_rd_en   <= gpr_rd_en_d;
            gpr_rd_addr <= gpr_rd_addr_d;
            ram_rd_req  <= ram_rd_req_d;
            ram_rd_addr <= ram_rd_addr_d;
            out_valid   <= out_valid_d;
            out_data    <= out_data_d;
            out_dst_ram <= out_dst_ram_d;
            err_illegal <= err_illegal_d;
            err_timeout <= err_timeout_d;
        end
    end

    // Next-state and next-output logic; strobes default low, data holds.
    always_comb begin
        state_d       = state_q;
        opc_d         = opc_q;
        rd_d          = rd_q;
        addr_d        = addr_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        gpr_rd_en_d   = 1'b0;
        gpr_rd_addr_d = gpr_rd_addr;
        ram_rd_req_d  = 1'b0;
        ram_rd_addr_d = ram_rd_addr;
        out_valid_d   = 1'b0;
        out_data_d    = out_data;
        out_dst_ram_d = out_dst_ram;
        err_illegal_d = 1'b0;
        err_timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_valid && instr_ready) begin
                    opc_d  = in_opc;
                    rd_d   = in_rd;
                    addr_d = in_addr;
                    case (in_opc)
                        OP_MOV_SR, OP_INC_SR, OP_DEC_SR: begin
                            state_d       = S_GPR_RD;
                            gpr_rd_en_d   = 1'b1;
                            gpr_rd_addr_d = in_rd;
                        end
                        OP_MOV_BIO, OP_INC_BIO, OP_DEC_BIO: begin
                            state_d       = S_GPR_RD;
                            gpr_rd_en_d   = 1'b1;
                            gpr_rd_addr_d = in_rs;
                        end
                        OP_MOV_SA: begin
                            state_d       = S_RAM_RD;
                            ram_rd_req_d  = 1'b1;
                            ram_rd_addr_d = in_addr;
                            cnt_d         = '0;
                        end
                        default: err_illegal_d = 1'b1;
                    endcase
                end
            end
            S_GPR_RD: state_d = S_GPR_CAP;
            S_GPR_CAP: begin
                op_d = gpr_rd_data;
                if (opc_q == OP_MOV_BIO || opc_q == OP_INC_BIO || opc_q == OP_DEC_BIO) begin
                    state_d       = S_RAM_RD;
                    ram_rd_req_d  = 1'b1;
                    ram_rd_addr_d = gpr_rd_data[ADDR_W-1:0];
                    cnt_d         = '0;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_RAM_RD: begin
                // A grant wins over a timeout landing in the same cycle.
                if (ram_rd_gnt) begin
                    op_d    = ram_rd_data;
                    state_d = S_EXEC;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    state_d       = S_IDLE;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d        = cnt_q + CNT_W'(1);
                    ram_rd_req_d = 1'b1;
                end
            end
            S_EXEC: begin
                state_d     = S_OUT;
                out_valid_d = 1'b1;
                case (opc_q)
                    OP_MOV_SR: begin
                        out_data_d    = {op_q, addr_q, opc_q};
                        out_dst_ram_d = 1'b1;
                    end
                    OP_INC_SR: begin
                        out_data_d    = {op_q + DATA_W'(1), ADDR_W'(rd_q), opc_q};
                        out_dst_ram_d = 1'b0;
                    end
                    OP_DEC_SR: begin
                        out_data_d    = {op_q - DATA_W'(1), ADDR_W'(rd_q), opc_q};
                        out_dst_ram_d = 1'b0;
                    end
                    OP_INC_BIO: begin
                        out_data_d    = {op_q + DATA_W'(1), ram_rd_addr, opc_q};
                        out_dst_ram_d = 1'b1;
                    end
                    OP_DEC_BIO: begin
                        out_data_d    = {op_q - DATA_W'(1), ram_rd_addr, opc_q};
                        out_dst_ram_d = 1'b1;
                    end
                    default: begin
                        out_data_d    = {op_q, ADDR_W'(rd_q), opc_q};
                        out_dst_ram_d = 1'b0;
                    end
                endcase
            end
            S_OUT: begin
                if (out_ready) state_d = S_IDLE;
                else           out_valid_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        instr_ready_d = (state_d == S_IDLE);
    end

endmodule

// File: tb/tb_decode_exec_unit.sv
// Directed bench for decode_exec_unit with GPR/RAM responders and a record scoreboard.
module tb_decode_exec_unit;

    typedef struct packed {
        logic [13:0] data;
        logic [11:0] addr;
        logic [3:0]  opc;
        logic        dst;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [27:0] instr;
    logic        gpr_rd_en;
    logic [3:0]  gpr_rd_addr;
    logic [13:0] gpr_rd_data;
    logic        ram_rd_req;
    logic [11:0] ram_rd_addr;
    logic        ram_rd_gnt = 1'b0;
    logic [13:0] ram_rd_data = 14'h0;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_data;
    logic        out_dst_ram;
    logic        err_illegal;
    logic        err_timeout;

    int n_cmp = 0;
    int n_fail = 0;
    rec_t sb_q[$];

    logic [13:0] gpr_mem [0:15];
    logic [13:0] ram_mem [0:4095];
    int          gnt_after = 0;
    int          req_cnt = 0;
    int          req_len = 0;
    logic        addr_bad = 1'b0;
    logic [11:0] req_addr0 = 12'h0;
    int          to_pulses = 0;
    int          ill_pulses = 0;

    always #5 clk = ~clk;

    decode_exec_unit #(
        .DATA_W(14), .ADDR_W(12), .GPR_AW(4), .OPC_W(4), .TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .gpr_rd_en(gpr_rd_en), .gpr_rd_addr(gpr_rd_addr), .gpr_rd_data(gpr_rd_data),
        .ram_rd_req(ram_rd_req), .ram_rd_addr(ram_rd_addr),
        .ram_rd_gnt(ram_rd_gnt), .ram_rd_data(ram_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dst_ram(out_dst_ram), .err_illegal(err_illegal), .err_timeout(err_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] mk(input logic [3:0] opc, input logic [3:0] rd,
                                       input logic [11:0] addr, input logic [3:0] rs);
        return {opc, rd, addr, rs, 4'h0};
    endfunction

    function automatic rec_t mkrec(input logic [13:0] d, input logic [11:0] a,
                                   input logic [3:0] o, input logic dst);
        rec_t r;
        r.data = d; r.addr = a; r.opc = o; r.dst = dst;
        return r;
    endfunction

    // GPR file: registered read, junk when not addressed so early/late capture shows.
    always @(posedge clk) gpr_rd_data <= gpr_rd_en ? gpr_mem[gpr_rd_addr] : 14'h2AAA;

    // RAM arbiter: grants in the gnt_after-th request cycle (0 = never).
    always @(negedge clk) begin
        if (ram_rd_req) begin
            req_cnt = req_cnt + 1;
            if (req_cnt == 1) req_addr0 = ram_rd_addr;
            else if (ram_rd_addr != req_addr0) addr_bad = 1'b1;
            ram_rd_gnt  = (gnt_after != 0) && (req_cnt == gnt_after);
            ram_rd_data = ram_rd_gnt ? ram_mem[ram_rd_addr] : 14'h2555;
        end else begin
            if (req_cnt != 0) req_len = req_cnt;
            req_cnt    = 0;
            ram_rd_gnt = 1'b0;
        end
        if (err_timeout) to_pulses++;
        if (err_illegal) ill_pulses++;
    end

    // Record monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        #2;
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_nonempty", 64'(sb_q.size()), 64'd1);
            end else begin
                rec_t e;
                e = sb_q.pop_front();
                chk("record", 64'({out_data, out_dst_ram}), 64'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [27:0] w);
        int n = 0;
        while (!instr_ready && n < 50) begin @(negedge clk); n++; end
        chk("ready_before_send", 64'(instr_ready), 64'd1);
        instr = w;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr = '0;
    endtask

    task automatic expect_out(input int k0, input int exp_lat, input string tag);
        int k = k0;
        while (!out_valid && k < 80) begin @(negedge clk); k++; end
        chk({tag, "_latency"}, 64'(k), 64'(exp_lat));
        @(negedge clk);
        chk({tag, "_valid_fall"}, 64'(out_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(instr_ready), 64'd1);
    endtask

    initial begin
        logic [29:0] held;
        int ov, et, et_k, k;
        reset = 1'b1; instr_valid = 1'b0; instr = '0; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) gpr_mem[i] = 14'(16'h0100 + i);
        gpr_mem[3] = 14'h1234; gpr_mem[5] = 14'h0020; gpr_mem[2] = 14'h0000; gpr_mem[6] = 14'h3045;
        ram_mem[12'h100] = 14'h0ABC; ram_mem[12'h020] = 14'h3FFF; ram_mem[12'h045] = 14'h1111;
        ram_mem[12'h200] = 14'h0777; ram_mem[12'h300] = 14'h0333;
        repeat (3) @(negedge clk);

        chk("rst_instr_ready", 64'(instr_ready), 64'd0);
        chk("rst_gpr_rd_en",   64'(gpr_rd_en),   64'd0);
        chk("rst_ram_rd_req",  64'(ram_rd_req),  64'd0);
        chk("rst_out_valid",   64'(out_valid),   64'd0);
        chk("rst_out_data",    64'(out_data),    64'd0);
        chk("rst_out_dst_ram", 64'(out_dst_ram), 64'd0);
        chk("rst_err",         64'({err_illegal, err_timeout}), 64'd0);
        chk("rst_addrs",       64'({gpr_rd_addr, ram_rd_addr}), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(instr_ready), 64'd1);

        // MOV_SR
        sb_q.push_back(mkrec(14'h1234, 12'h0A5, 4'd0, 1'b1));
        send(mk(4'd0, 4'd3, 12'h0A5, 4'd0));
        chk("sr_gpr_en",    64'(gpr_rd_en),   64'd1);
        chk("sr_gpr_addr",  64'(gpr_rd_addr), 64'd3);
        chk("sr_busy",      64'(instr_ready), 64'd0);
        @(negedge clk);
        chk("sr_gpr_en_once", 64'(gpr_rd_en), 64'd0);
        expect_out(2, 4, "mov_sr");

        // MOV_SA, grant in the fifth request cycle
        gnt_after = 5; req_len = 0; addr_bad = 1'b0;
        sb_q.push_back(mkrec(14'h0ABC, 12'h007, 4'd1, 1'b0));
        send(mk(4'd1, 4'd7, 12'h100, 4'd0));
        chk("sa_req",    64'(ram_rd_req),  64'd1);
        chk("sa_addr",   64'(ram_rd_addr), 64'h100);
        chk("sa_no_gpr", 64'(gpr_rd_en),   64'd0);
        expect_out(1, 7, "mov_sa");
        chk("sa_req_len",     64'(req_len),  64'd5);
        chk("sa_addr_stable", 64'(addr_bad), 64'd0);

        // INC_BIO wrapping all-ones to zero
        gnt_after = 1;
        sb_q.push_back(mkrec(14'h0000, 12'h020, 4'd4, 1'b1));
        send(mk(4'd4, 4'd0, 12'h000, 4'd5));
        chk("incbio_gpr_addr", 64'(gpr_rd_addr), 64'd5);
        @(negedge clk);
        chk("incbio_no_req_yet", 64'(ram_rd_req), 64'd0);
        @(negedge clk);
        chk("incbio_req",  64'(ram_rd_req),  64'd1);
        chk("incbio_addr", 64'(ram_rd_addr), 64'h020);
        expect_out(3, 5, "inc_bio");

        // DEC_SR wrapping zero to all-ones, INC_SR
        sb_q.push_back(mkrec(14'h3FFF, 12'h002, 4'd5, 1'b0));
        send(mk(4'd5, 4'd2, 12'hFFF, 4'd0));
        expect_out(1, 4, "dec_sr");
        sb_q.push_back(mkrec(14'h1235, 12'h003, 4'd3, 1'b0));
        send(mk(4'd3, 4'd3, 12'h000, 4'd0));
        expect_out(1, 4, "inc_sr");

        // MOV_BIO: pointer is the low ADDR_W bits of the GPR value
        gnt_after = 2;
        sb_q.push_back(mkrec(14'h1111, 12'h009, 4'd2, 1'b0));
        send(mk(4'd2, 4'd9, 12'h000, 4'd6));
        repeat (2) @(negedge clk);
        chk("movbio_addr", 64'(ram_rd_addr), 64'h045);
        expect_out(3, 6, "mov_bio");

        // DEC_BIO
        gnt_after = 3;
        sb_q.push_back(mkrec(14'h3FFE, 12'h020, 4'd6, 1'b1));
        send(mk(4'd6, 4'd0, 12'h000, 4'd5));
        expect_out(1, 7, "dec_bio");

        // Timeout: no grant at all
        gnt_after = 0; req_len = 0;
        ov = 0; et = 0; et_k = 0;
        send(mk(4'd1, 4'd4, 12'h200, 4'd0));
        for (k = 1; k <= 24; k++) begin
            if (k > 1) @(negedge clk);
            if (out_valid) ov++;
            if (err_timeout) begin et++; et_k = k; end
        end
        chk("to_no_valid",   64'(ov),          64'd0);
        chk("to_pulse_len",  64'(et),          64'd1);
        chk("to_pulse_time", 64'(et_k),        64'd16);
        chk("to_req_len",    64'(req_len),     64'd15);
        chk("to_ready_back", 64'(instr_ready), 64'd1);

        // Grant coincides with the timeout count: grant wins
        gnt_after = 15; req_len = 0;
        sb_q.push_back(mkrec(14'h0ABC, 12'h001, 4'd1, 1'b0));
        send(mk(4'd1, 4'd1, 12'h100, 4'd0));
        expect_out(1, 17, "gnt_at_limit");
        chk("limit_req_len",  64'(req_len),   64'd15);
        chk("limit_no_to",    64'(to_pulses), 64'd1);

        // Illegal opcodes 0xF and 7
        send(mk(4'hF, 4'd1, 12'h001, 4'd1));
        chk("ill_pulse",   64'(err_illegal), 64'd1);
        chk("ill_ready",   64'(instr_ready), 64'd1);
        chk("ill_no_fetch", 64'({gpr_rd_en, ram_rd_req}), 64'd0);
        @(negedge clk);
        chk("ill_pulse_end", 64'(err_illegal), 64'd0);
        chk("ill_no_fetch2", 64'({gpr_rd_en, ram_rd_req}), 64'd0);
        send(mk(4'd7, 4'd1, 12'h001, 4'd1));
        @(negedge clk);
        chk("ill_count", 64'(ill_pulses), 64'd2);

        // Backpressure on the record port
        out_ready = 1'b0;
        sb_q.push_back(mkrec(14'h1234, 12'h0A5, 4'd0, 1'b1));
        send(mk(4'd0, 4'd3, 12'h0A5, 4'd0));
        k = 1;
        while (!out_valid && k < 80) begin @(negedge clk); k++; end
        chk("bp_latency", 64'(k), 64'd4);
        held = out_data;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_valid_held", 64'(out_valid),   64'd1);
            chk("bp_data_stable", 64'(out_data),   64'(held));
            chk("bp_not_ready",  64'(instr_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_fall", 64'(out_valid), 64'd0);

        // Reset while waiting in RAM_RD
        gnt_after = 0;
        send(mk(4'd1, 4'd2, 12'h300, 4'd0));
        repeat (2) @(negedge clk);
        chk("mid_req_up", 64'(ram_rd_req), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_req_drop",  64'(ram_rd_req),  64'd0);
        chk("mid_valid_low", 64'(out_valid),   64'd0);
        chk("mid_ready_rst", 64'(instr_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_idle",     64'(instr_ready), 64'd1);
        chk("mid_no_error", 64'({err_illegal, err_timeout}), 64'd0);

        // Normal operation after the reset
        sb_q.push_back(mkrec(14'h1233, 12'h003, 4'd5, 1'b0));
        send(mk(4'd5, 4'd3, 12'h000, 4'd0));
        expect_out(1, 4, "post_rst");

        repeat (3) @(negedge clk);
        chk("sb_empty",      64'(sb_q.size()), 64'd0);
        chk("to_pulses_end", 64'(to_pulses),   64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
